ntm_modular_inverter: RTL

NTM_MODULAR_INVERTER -- requirements
Module: ntm_modular_inverter

---
 rtl/ntm_modular_inverter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ntm_modular_inverter.sv
// Modular inverse a^-1 mod m by the binary extended Euclidean algorithm.
// Optional ERROR output enabled by defining NTM_MODULAR_INVERTER_ERROR_EN.
module ntm_modular_inverter #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  input  logic [DATA_SIZE-1:0] DATA_X_IN,
`ifdef NTM_MODULAR_INVERTER_ERROR_EN
  output logic                 ERROR,
`endif
  output logic                 READY,
  output logic [DATA_SIZE-1:0] DATA_OUT
);

  localparam int W = DATA_SIZE + 1;

  typedef enum logic [2:0] {
    STARTER  = 3'd0,
    REDUCE   = 3'd1,
    CHECK    = 3'd2,
    HALVE_U  = 3'd3,
    HALVE_V  = 3'd4,
    SUBTRACT = 3'd5,
    ENDER    = 3'd6
  } state_t;

  state_t                  r_state, w_next;
  logic [W-1:0]            r_u, r_v, r_x1, r_x2;
  logic                    r_inv;
  logic                    r_ready;
  logic [DATA_SIZE-1:0]    r_out;
  logic [CONTROL_SIZE-1:0] r_steps;

  logic [W-1:0] w_m, w_a;
  logic         w_bad_mod;
  logic [W-1:0] w_x1_half, w_x2_half, w_x1_sub, w_x2_sub;

  assign w_m       = {1'b0, DATA_X_IN};
  assign w_a       = {1'b0, DATA_IN};
  assign w_bad_mod = ~DATA_X_IN[0] | (DATA_X_IN < DATA_SIZE'(3));

  // x stays in [0, m); the extra bit keeps x + m from overflowing.
  assign w_x1_half = r_x1[0] ? ((r_x1 + w_m) >> 1) : (r_x1 >> 1);
  assign w_x2_half = r_x2[0] ? ((r_x2 + w_m) >> 1) : (r_x2 >> 1);
  assign w_x1_sub  = (r_x1 >= r_x2) ? (r_x1 - r_x2) : (r_x1 + w_m - r_x2);
  assign w_x2_sub  = (r_x2 >= r_x1) ? (r_x2 - r_x1) : (r_x2 + w_m - r_x1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= STARTER;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      STARTER:  if (START) w_next = w_bad_mod ? ENDER : REDUCE;
      REDUCE:   if (r_u < w_m) w_next = CHECK;
      CHECK: begin
        if (r_u == '0 || r_v == '0 || r_u == W'(1) || r_v == W'(1)) w_next = ENDER;
        else if (!r_u[0])                                           w_next = HALVE_U;
        else if (!r_v[0])                                           w_next = HALVE_V;
        else                                                        w_next = SUBTRACT;
      end
      HALVE_U, HALVE_V, SUBTRACT: w_next = CHECK;
      ENDER:    w_next = STARTER;
      default:  w_next = STARTER;
    endcase
  end

`ifdef NTM_MODULAR_INVERTER_ERROR_EN
  logic r_err;
  assign ERROR = r_err;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_u     <= '0;
      r_v     <= '0;
      r_x1    <= '0;
      r_x2    <= '0;
      r_inv   <= 1'b0;
      r_ready <= 1'b0;
      r_out   <= '0;
      r_steps <= '0;
`ifdef NTM_MODULAR_INVERTER_ERROR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_ready <= 1'b0;
      r_steps <= (r_state == STARTER) ? '0 : r_steps + 1'b1;
      case (r_state)
        STARTER: if (START) begin
          if (w_bad_mod) r_inv <= 1'b1;
          else begin
            r_inv <= 1'b0;
            r_u   <= w_a;
            r_v   <= w_m;
            r_x1  <= W'(1);
            r_x2  <= '0;
          end
        end
        REDUCE:   if (r_u >= w_m) r_u <= r_u - w_m;
        CHECK:    if (r_u == '0 || r_v == '0) r_inv <= 1'b1;
        HALVE_U: begin
          r_u  <= r_u >> 1;
          r_x1 <= w_x1_half;
        end
        HALVE_V: begin
          r_v  <= r_v >> 1;
          r_x2 <= w_x2_half;
        end
        SUBTRACT: begin
          if (r_u >= r_v) begin
            r_u  <= r_u - r_v;
            r_x1 <= w_x1_sub;
          end else begin
            r_v  <= r_v - r_u;
            r_x2 <= w_x2_sub;
          end
        end
        ENDER: begin
          r_ready <= 1'b1;
          if (r_inv)            r_out <= '0;
          else if (r_u == W'(1)) r_out <= r_x1[DATA_SIZE-1:0];
          else                  r_out <= r_x2[DATA_SIZE-1:0];
`ifdef NTM_MODULAR_INVERTER_ERROR_EN
          r_err <= r_inv;
`endif
        end
        default: ;
      endcase
    end
  end

  assign READY    = r_ready;
  assign DATA_OUT = r_out;

endmodule
